// File: rtl/bc_pkg.sv
// Shared definitions for the breadcrumb SPI slave: default word geometry and FSM states.
package bc_pkg;

  localparam int                    BC_WORD_W    = 16;
  localparam logic [BC_WORD_W-1:0]  BC_IDLE_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    WAIT_CS = 2'd3
  } bc_spi_state_t;

endpackage

// File: rtl/bc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with registered rise/fall strobes.
// STAGES must be at least 2. RST_VAL is the pin's idle level so reset creates no false edge.
module bc_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  assign level = sync_q[STAGES-1];

  // Shift the pin through the synchronizer and compare the settled value with its last sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/bc_spi_slave.sv
// SPI mode-0 slave for the breadcrumb buffer, fully oversampled in the clk domain.
// Receives one WORD_W word per frame into rx_data and shifts out a word prefetched
// from the avoid-out FIFO (or IDLE_WORD when none is held).
module bc_spi_slave
  import bc_pkg::*;
#(
  parameter int                WORD_W      = BC_WORD_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD   = WORD_W'(BC_IDLE_WORD),
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rdy,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_rdy,
  output logic [CNT_W-1:0]  rx_overflow_cnt,
  output logic              frame_err
);

  localparam int BIT_W = $clog2(WORD_W + 1);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  bc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_sck),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  bc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  bc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  bc_spi_state_t     state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] tx_hold;
  logic              hold_full;
  logic              cap_pending;  // pop issued last cycle; FIFO data valid this cycle
  logic              from_hold;    // current frame is transmitting tx_hold
  logic              extra_seen;   // an over-long frame has already been flagged

  // MISO follows the tx shifter whenever a frame is in progress, and idles low otherwise.
  assign spi_miso = (state != IDLE) & tx_shift[WORD_W-1];

  // Frame FSM, tx prefetch, rx hand-off and overflow accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      // NOTE: the hold register is a single word, so it is reset like any other flop;
      // hold_full alone decides whether its contents are meaningful.
      tx_hold         <= '0;
      hold_full       <= 1'b0;
      cap_pending     <= 1'b0;
      from_hold       <= 1'b0;
      extra_seen      <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      tx_rdy          <= 1'b0;
      rx_overflow_cnt <= '0;
      frame_err       <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      // Pop only from a quiet IDLE, one request at a time, never as a frame opens.
      tx_rdy      <= (state == IDLE) && !cs_fall && tx_valid && !hold_full &&
                     !tx_rdy && !cap_pending;
      cap_pending <= tx_rdy;
      if (cap_pending) begin
        tx_hold   <= tx_data;
        hold_full <= 1'b1;
      end

      if (rx_valid && rx_rdy) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift   <= hold_full ? tx_hold : IDLE_WORD;
            from_hold  <= hold_full;
            bit_cnt    <= '0;
            extra_seen <= 1'b0;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // A partial word is discarded; the held tx word stays for a retry.
            if (bit_cnt != '0) frame_err <= 1'b1;
            state <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[WORD_W-2:0], mosi_level};
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(WORD_W - 1)) state <= DONE;
          end else if (sck_fall && (bit_cnt != '0) && (bit_cnt < BIT_W'(WORD_W))) begin
            tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
          end
        end

        DONE: begin
          if (!rx_valid) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else if (rx_overflow_cnt != {CNT_W{1'b1}}) begin
            rx_overflow_cnt <= rx_overflow_cnt + CNT_W'(1);
          end
          if (from_hold) hold_full <= 1'b0;
          state <= cs_rise ? IDLE : WAIT_CS;
        end

        WAIT_CS: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_rise && !extra_seen) begin
            frame_err  <= 1'b1;
            extra_seen <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bc_spi_slave.sv
// Self-checking bench for bc_spi_slave: an SPI master driver, a FIFO model behind tx,
// and a frame-level reference model of rx delivery, overflow counting and frame errors.
module tb_bc_spi_slave;

  localparam int W  = 16;
  localparam int S  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spi_sck = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          rx_rdy = 1'b1;
  logic [W-1:0]  tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_rdy;
  logic [CW-1:0] rx_overflow_cnt;
  logic          frame_err;

  bc_spi_slave #(
    .WORD_W      (W),
    .SYNC_STAGES (S),
    .IDLE_WORD   (16'h0000),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .spi_sck         (spi_sck),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_rdy          (rx_rdy),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_rdy          (tx_rdy),
    .rx_overflow_cnt (rx_overflow_cnt),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- avoid-out FIFO model (standard read, data one cycle after rd_en)
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] shadow_q[$];
  int           pops_seen = 0;
  int           fe_seen   = 0;

  always @(negedge clk) begin
    if (tx_rdy) begin
      pops_seen++;
      if (fifo_q.size() > 0) tx_data = fifo_q.pop_front();
    end
    tx_valid = (fifo_q.size() > 0);
    if (frame_err) fe_seen++;
  end

  task automatic push_tx(input logic [W-1:0] w);
    fifo_q.push_back(w);
    shadow_q.push_back(w);
  endtask

  // ---------------- reference model of the rx side
  typedef struct {
    int           at;
    bit           err;
    logic [W-1:0] w;
  } ev_t;

  ev_t           ev_q[$];
  int            cyc     = 0;
  logic          e_valid = 1'b0;
  logic [W-1:0]  e_data  = '0;
  logic [CW-1:0] e_ovf   = '0;
  logic          e_err   = 1'b0;
  logic          m_nv;
  ev_t           m_cur;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid = 1'b0;
      e_data  = '0;
      e_ovf   = '0;
      e_err   = 1'b0;
      ev_q.delete();
    end else begin
      cyc++;
      m_nv  = e_valid && !rx_rdy;
      e_err = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        m_cur = ev_q.pop_front();
        if (m_cur.err) e_err = 1'b1;
        else if (e_valid) begin
          if (e_ovf != 8'hFF) e_ovf = e_ovf + 8'd1;
        end else begin
          m_nv   = 1'b1;
          e_data = m_cur.w;
        end
      end
      e_valid = m_nv;
    end
  end

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("rx_valid", rx_valid, e_valid);
    check("rx_data", rx_data, e_data);
    check("rx_overflow_cnt", rx_overflow_cnt, e_ovf);
    check("frame_err", frame_err, e_err);
  end

  // ---------------- tx hold model and SPI master
  logic         mh_valid = 1'b0;
  logic [W-1:0] mh_word  = '0;
  int           exp_pops = 0;

  // bits[31] is the first bit on MOSI; nbits sck pulses; half = clk cycles per sck phase.
  task automatic frame(input logic [31:0] bits, input int nbits, input int half,
                       input bit rst_abort, output logic [W-1:0] miso_word);
    logic [W-1:0] got;
    logic [W-1:0] exp_word;
    ev_t          e;
    int           nb;
    got = '0;
    repeat (8) @(negedge clk);
    if (!mh_valid && shadow_q.size() > 0) begin
      mh_word  = shadow_q.pop_front();
      mh_valid = 1'b1;
      exp_pops++;
    end
    check("pops_before_frame", pops_seen, exp_pops);
    exp_word = mh_valid ? mh_word : 16'h0000;

    spi_cs_n = 1'b0;
    spi_mosi = bits[31];
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_sck = 1'b1;
      if (i < W) got = {got[W-2:0], spi_miso};
      if (i == W - 1) begin
        e.at = cyc + S + 3; e.err = 1'b0; e.w = bits[31:16];
        ev_q.push_back(e);
      end
      if (i == W) begin
        e.at = cyc + S + 2; e.err = 1'b1; e.w = '0;
        ev_q.push_back(e);
      end
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
      if (i < 31) spi_mosi = bits[30 - i];
      repeat (half) @(negedge clk);
    end

    nb = (nbits < W) ? nbits : W;
    check("miso_word", got, exp_word >> (W - nb));
    check("no_pop_in_frame", pops_seen, exp_pops);
    miso_word = got;

    if (rst_abort) begin
      #2;
      rst      = 1'b0;
      spi_cs_n = 1'b1;
      mh_valid = 1'b0;
    end else begin
      spi_cs_n = 1'b1;
      if (nbits > 0 && nbits < W) begin
        e.at = cyc + S + 2; e.err = 1'b1; e.w = '0;
        ev_q.push_back(e);
      end
      if (nbits >= W) mh_valid = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 1'b0);
    check({tag, "_rx_data"}, rx_data, 16'h0000);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_tx_rdy"}, tx_rdy, 1'b0);
    check({tag, "_ovf"}, rx_overflow_cnt, 8'h00);
    check({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  logic [W-1:0] got_w;
  int           p0;
  int           f0;
  int           nb_r;
  logic [W-1:0] w_r;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b1;

    // Frame with nothing held: MISO idles at 0000, A5C3 delivered and accepted.
    rx_rdy = 1'b1;
    frame({16'hA5C3, 16'h0}, 16, 4, 1'b0, got_w);
    check("t1_miso", got_w, 16'h0000);
    check("t1_rx_data", rx_data, 16'hA5C3);
    check("t1_rx_valid_cleared", rx_valid, 1'b0);

    // One prefetch of 1234, transmitted once; next frame with FIFO empty gives 0000.
    p0 = pops_seen;
    push_tx(16'h1234);
    frame({16'h0F00, 16'h0}, 16, 4, 1'b0, got_w);
    check("t2_one_pop", pops_seen - p0, 1);
    check("t2_miso", got_w, 16'h1234);
    frame({16'h00F0, 16'h0}, 16, 5, 1'b0, got_w);
    check("t2_miso_empty", got_w, 16'h0000);
    check("t2_still_one_pop", pops_seen - p0, 1);

    // Sink stalled: second word dropped, then the counter saturates.
    rx_rdy = 1'b0;
    frame({16'h0001, 16'h0}, 16, 4, 1'b0, got_w);
    frame({16'h0002, 16'h0}, 16, 4, 1'b0, got_w);
    check("t3_rx_data_kept", rx_data, 16'h0001);
    check("t3_ovf_one", rx_overflow_cnt, 8'h01);
    for (int i = 0; i < 300; i++) frame({16'($urandom), 16'h0}, 16, 4, 1'b0, got_w);
    check("t3_ovf_sat", rx_overflow_cnt, 8'hFF);
    check("t3_rx_data_still", rx_data, 16'h0001);
    rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_rx_valid_drained", rx_valid, 1'b0);

    // Aborted frame after 7 bits: one frame_err, no word, BEEF retransmitted.
    push_tx(16'hBEEF);
    f0 = fe_seen;
    frame({16'h7E7E, 16'h0}, 7, 4, 1'b0, got_w);
    check("t4_fe_once", fe_seen - f0, 1);
    check("t4_partial_miso", got_w, 16'h005F);
    frame({16'h1111, 16'h0}, 16, 4, 1'b0, got_w);
    check("t4_retransmit", got_w, 16'hBEEF);
    check("t4_rx_data", rx_data, 16'h1111);

    // Over-long frame: 18 pulses, word kept, one frame_err.
    f0 = fe_seen;
    frame({16'h0F0F, 2'b11, 14'h0}, 18, 4, 1'b0, got_w);
    check("t5_rx_data", rx_data, 16'h0F0F);
    check("t5_fe_once", fe_seen - f0, 1);

    // Reset mid-frame after 9 bits, with a word held.
    push_tx(16'hCAFE);
    frame({16'hFFFF, 16'h0}, 9, 4, 1'b1, got_w);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #2 rst = 1'b1;
    push_tx(16'h3C3C);
    frame({16'h5555, 16'h0}, 16, 4, 1'b0, got_w);
    check("t6_rx_data", rx_data, 16'h5555);
    check("t6_miso_after_reset", got_w, 16'h3C3C);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) push_tx(16'($urandom));
      rx_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       nb_r = 5;
        1:       nb_r = 17;
        default: nb_r = 16;
      endcase
      w_r = 16'($urandom);
      frame({w_r, 16'($urandom)}, nb_r, $urandom_range(4, 6), 1'b0, got_w);
    end
    rx_rdy = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bc_spi_slave.md
# bc_spi_slave

SPI slave front end for the breadcrumb buffer, replacing the dropped SERDES path. It receives 16-bit breadcrumbs serially from the Avoidance MCU and pushes them into the buffer's avoid-in FIFO. In the same frame it shifts out words popped from the buffer's avoid-out FIFO. Everything runs in the `clk` domain: SPI pins are oversampled through synchronizers, so there is no `sck` clock domain.

## Interface
Parameters:
- `WORD_W`, 16, breadcrumb width and bits per frame
- `SYNC_STAGES`, 2, synchronizer depth on `spi_sck`, `spi_cs_n` and `spi_mosi`
- `IDLE_WORD`, 16'h0000, word shifted out when no tx word is held
- `CNT_W`, 8, width of the overflow counter

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- `spi_cs_n`  in  1  frame select, active-low
- `spi_mosi`  in  1  serial data in, MSB first
- `spi_miso`  out  1  serial data out, MSB first
- `rx_data`  out  WORD_W  received word, to `avoid_in_data`
- `rx_valid`  out  1  `rx_data` holds an undelivered word
- `rx_rdy`  in  1  sink can accept (`~full`)
- `tx_data`  in  WORD_W  word from the avoid-out FIFO
- `tx_valid`  in  1  FIFO not empty
- `tx_rdy`  out  1  one-cycle pop strobe (FIFO `rd_en`)
- `rx_overflow_cnt`  out  CNT_W  words dropped because `rx_valid` was still pending; saturates
- `frame_err`  out  1  one-cycle pulse on an aborted or over-long frame

## Operation
- All SPI inputs pass through `SYNC_STAGES` flops. The edge detector produces `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise`.
- **Tx prefetch**
  - When `hold_full`=0, `tx_valid`=1 and the FSM is in IDLE, assert `tx_rdy` for one cycle.
  - Capture `tx_data` into `tx_hold` on the next cycle (standard-read FIFO, latency 1) and set `hold_full`.
  - No pop is issued while a frame is active.
- **FSM states**
  - IDLE: on `cs_fall`, load `tx_shift` from `tx_hold` if `hold_full`, otherwise from `IDLE_WORD`. Clear `bit_cnt`, then go to SHIFT.
  - SHIFT:
    - On `sck_rise`: `rx_shift <= {rx_shift[WORD_W-2:0], mosi}` and `bit_cnt++`.
    - On `sck_fall` with 0 < `bit_cnt` < WORD_W: `tx_shift <<= 1`.
    - When `bit_cnt` reaches WORD_W, go to DONE.
  - DONE:
    - Deliver `rx_shift`: if `rx_valid`=0, load `rx_data` and set `rx_valid`; otherwise drop the word and increment `rx_overflow_cnt` (saturating).
    - If the word came from `tx_hold`, clear `hold_full`.
    - Go to WAIT_CS.
  - WAIT_CS: ignore further `sck` edges. On the first extra `sck_rise`, pulse `frame_err` once. On `cs_rise`, go to IDLE.
  - Any state: `cs_rise` while in SHIFT with `bit_cnt` != 0 discards the partial word, pulses `frame_err`, and returns to IDLE. `hold_full` and `tx_hold` are kept, so the word is retransmitted. `cs_rise` with `bit_cnt`=0 returns to IDLE silently.
- `rx_valid` clears on the cycle after `rx_valid & rx_rdy`.
- `spi_miso = tx_shift[WORD_W-1]` while in SHIFT or DONE/WAIT_CS; otherwise 0.

## Timing
- Reset values: `spi_miso`=0, `rx_data`=0, `rx_valid`=0, `tx_rdy`=0, `rx_overflow_cnt`=0, `frame_err`=0, FSM=IDLE, `hold_full`=0.
- Reset mid-frame aborts silently with no `frame_err`. The held tx word is lost.
- External constraints:
  - `sck` high and low each ≥ 4 `clk` cycles.
  - `cs_n` fall to first `sck` rise ≥ 6 `clk` cycles.
  - Last `sck` fall to `cs_n` rise ≥ 4 `clk` cycles.
- `rx_valid` asserts `SYNC_STAGES`+2 `clk` cycles after the 16th `spi_sck` rising edge at the pin.
- MSB on `spi_miso` is valid `SYNC_STAGES`+1 cycles after `spi_cs_n` falls.
- Simultaneous `sck_rise` and `cs_rise` in one cycle: `cs_rise` wins and the bit is not counted.
- Re-pop occurs no earlier than 1 cycle after returning to IDLE.

## Structure
- Package `bc_pkg`: `WORD_W` default, `IDLE_WORD`, and the `bc_spi_state_t` enum {IDLE, SHIFT, DONE, WAIT_CS}.
- Sub-module `bc_sync_edge`: `SYNC_STAGES` synchronizer plus registered rise/fall detect, instantiated once per SPI input.
- The top level contains the FSM, `bit_cnt`, shift registers, tx hold register and overflow counter.

## Test plan
- Reset, then send frame MOSI=16'hA5C3 with `tx_hold` empty → MISO shifts 16'h0000; `rx_data`=16'hA5C3 with one `rx_valid`, accepted with `rx_rdy`=1.
- `tx_valid`=1 with FIFO word 16'h1234, then a frame → exactly one `tx_rdy` pulse before the frame; MISO=16'h1234; the following frame with FIFO empty returns 16'h0000.
- Hold `rx_rdy`=0 and send 16'h0001 then 16'h0002 → `rx_data` stays 16'h0001; `rx_overflow_cnt`=1. Send 300 more frames → counter saturates at 8'hFF.
- Tx word 16'hBEEF held; `cs_n` rises after 7 bits → `frame_err` pulses once, no `rx_valid`; the next full frame shifts out 16'hBEEF again.
- Send 18 `sck` pulses in one frame with MOSI=16'h0F0F followed by 2 extra bits → `rx_data`=16'h0F0F; `frame_err` pulses once.
- Assert `rst` low mid-frame after 9 bits → all outputs return to reset values asynchronously; the next full frame 16'h5555 is received correctly.
